// File: rtl/recibir_datos_pkg.sv
// recibir_datos_pkg: shared FSM states, bit-period helper and command width (RECIBIR_PARITY_EN adds PARITY)
package recibir_datos_pkg;
  localparam int CMD_W = 3;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RECIBIR_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/recibir_datos_sincronizador.sv
// sincronizador: 2-FF synchronizer for an asynchronous input, reset value selectable
module sincronizador #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;
  // shift the async sample through two stages
  always_comb sync_d = {sync_q[0], d};
  // synchronizer registers
  always_ff @(posedge clk)
    if (rst) sync_q <= {2{RST_VAL}};
    else sync_q <= sync_d;
  assign q = sync_q[1];
endmodule

// File: rtl/recibir_datos.sv
// recibir_datos: 8N1 UART receiver with command decode (RECIBIR_PARITY_EN selects 8E1)
module recibir_datos
  import recibir_datos_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [7:0]       datos,
  output logic             datos_valid,
  output logic [CMD_W-1:0] command,
  output logic             command_valid,
  output logic             frame_error,
  output logic             busy
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int TW  = $clog2(CPB);
  logic rx_s;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, datos_q, datos_d;
  logic [CMD_W-1:0] command_q, command_d;
  logic dv_q, dv_d, cv_q, cv_d, fe_q, fe_d, bad_frame;
  logic bit_end, mid_bit;
`ifdef RECIBIR_PARITY_EN
  logic par_err_q, par_err_d;
`endif
  sincronizador #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
  assign bit_end = timer_q == TW'(CPB - 1);
  assign mid_bit = timer_q == TW'(CPB / 2 - 1);
`ifdef RECIBIR_PARITY_EN
  assign bad_frame = !rx_s || par_err_q;
`else
  assign bad_frame = !rx_s;
`endif
  // next-state, bit sampling and strobe generation
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    datos_d   = datos_q;
    command_d = command_q;
    dv_d      = 1'b0;
    cv_d      = 1'b0;
    fe_d      = 1'b0;
`ifdef RECIBIR_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (mid_bit) begin
        timer_d = '0;
        state_d = rx_s ? IDLE : DATA;
`ifdef RECIBIR_PARITY_EN
        par_err_d = 1'b0;
`endif
      end
      DATA: if (bit_end) begin
        timer_d         = '0;
        shift_d[idx_q]  = rx_s;
        idx_d           = idx_q + 3'd1;
`ifdef RECIBIR_PARITY_EN
        state_d = idx_q == 3'd7 ? PARITY : DATA;
`else
        state_d = idx_q == 3'd7 ? STOP : DATA;
`endif
      end
`ifdef RECIBIR_PARITY_EN
      PARITY: if (bit_end) begin
        timer_d   = '0;
        par_err_d = rx_s != ^shift_q;
        state_d   = STOP;
      end
`endif
      STOP: if (bit_end) begin
        timer_d   = '0;
        dv_d      = !bad_frame;
        cv_d      = !bad_frame && shift_q[7:3] == 5'd0;
        fe_d      = bad_frame;
        datos_d   = bad_frame ? datos_q : shift_q;
        command_d = cv_d ? shift_q[CMD_W-1:0] : command_q;
        state_d   = rx_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        timer_d = '0;
        state_d = rx_s ? IDLE : WAIT_HIGH;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      datos_q   <= '0;
      command_q <= '0;
      dv_q      <= 1'b0;
      cv_q      <= 1'b0;
      fe_q      <= 1'b0;
`ifdef RECIBIR_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      datos_q   <= datos_d;
      command_q <= command_d;
      dv_q      <= dv_d;
      cv_q      <= cv_d;
      fe_q      <= fe_d;
`ifdef RECIBIR_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  assign datos         = datos_q;
  assign datos_valid   = dv_q;
  assign command       = command_q;
  assign command_valid = cv_q;
  assign frame_error   = fe_q;
  assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_recibir_datos.sv
// tb_recibir_datos: directed vector bench for the UART receiver at 16 clocks per bit
module tb_recibir_datos;
  localparam int CPB = 16;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] datos;
  logic [2:0] command;
  logic datos_valid, command_valid, frame_error, busy;
  int checks = 0, failures = 0;
  int dv_cnt = 0, cv_cnt = 0, fe_cnt = 0;
  int b_dv, b_cv, b_fe;
  logic [2:0] last_cmd = 3'd0, prev_cmd = 3'd0;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_datos;
    int         exp_dv;
    int         exp_cv;
    logic [2:0] exp_cmd;
    int         exp_fe;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  recibir_datos #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .datos(datos), .datos_valid(datos_valid),
    .command(command), .command_valid(command_valid), .frame_error(frame_error), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (datos_valid) dv_cnt++;
    if (frame_error) fe_cnt++;
    if (command_valid) begin
      cv_cnt++;
      prev_cmd = last_cmd;
      last_cmd = command;
    end
    if (command_valid || frame_error)
      chk("strobe_excl", {30'd0, datos_valid && frame_error, command_valid && !datos_valid}, 0);
  end

  task automatic bit_t(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_good, input int idle_bits);
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(d[i]);
`ifdef RECIBIR_PARITY_EN
    bit_t((^d) ^ !par_good);
`endif
    bit_t(stop);
    rx = 1'b1;
    repeat (idle_bits * CPB) @(negedge clk);
  endtask

  task automatic snap();
    b_dv = dv_cnt;
    b_cv = cv_cnt;
    b_fe = fe_cnt;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0, 3'd0, 0};
    vecs[1] = '{8'h05, 1'b1, 8'h05, 1, 1, 3'd5, 0};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 1, 1, 3'd0, 0};
    vecs[3] = '{8'h08, 1'b1, 8'h08, 1, 0, 3'd0, 0};
    vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1, 0, 3'd0, 0};
    vecs[5] = '{8'h3C, 1'b0, 8'hFF, 0, 0, 3'd0, 1};
    vecs[6] = '{8'h07, 1'b1, 8'h07, 1, 1, 3'd7, 0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_datos", datos, 0);
    chk("rst_command", command, 0);
    chk("rst_strobes", {datos_valid, command_valid, frame_error}, 0);
    chk("rst_busy", busy, 0);
    repeat (2 * CPB) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      snap();
      send_frame(vecs[i].d, vecs[i].stop, 1'b1, 2);
      chk($sformatf("v%0d_datos", i), datos, vecs[i].exp_datos);
      chk($sformatf("v%0d_dv", i), dv_cnt - b_dv, vecs[i].exp_dv);
      chk($sformatf("v%0d_cv", i), cv_cnt - b_cv, vecs[i].exp_cv);
      chk($sformatf("v%0d_fe", i), fe_cnt - b_fe, vecs[i].exp_fe);
      chk($sformatf("v%0d_cmd", i), command, vecs[i].exp_cmd);
    end
    snap();
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(i >= 2 && i <= 5);
    rx = 1'b0;
    repeat (41 * CPB) @(negedge clk);
    chk("brk_fe", fe_cnt - b_fe, 1);
    chk("brk_dv", dv_cnt - b_dv, 0);
    chk("brk_datos", datos, 8'h07);
    chk("brk_busy_low", busy, 1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("brk_busy_idle", busy, 0);
    repeat (2 * CPB) @(negedge clk);
    snap();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy_seen", busy, 1);
    for (int n = 0; n < 10 && busy; n++) @(negedge clk);
    chk("glitch_busy_clear", busy, 0);
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_strobes", (dv_cnt - b_dv) + (fe_cnt - b_fe) + (cv_cnt - b_cv), 0);
    snap();
    send_frame(8'h01, 1'b1, 1'b1, 0);
    send_frame(8'h02, 1'b1, 1'b1, 2);
    chk("b2b_dv", dv_cnt - b_dv, 2);
    chk("b2b_cv", cv_cnt - b_cv, 2);
    chk("b2b_cmd1", prev_cmd, 1);
    chk("b2b_cmd2", last_cmd, 2);
    chk("b2b_datos", datos, 8'h02);
    snap();
    bit_t(1'b0);
    for (int i = 0; i < 4; i++) bit_t(i != 0);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    chk("rstmid_strobes", (dv_cnt - b_dv) + (fe_cnt - b_fe) + (cv_cnt - b_cv), 0);
    chk("rstmid_datos", datos, 0);
    chk("rstmid_busy", busy, 0);
    snap();
    send_frame(8'h7E, 1'b1, 1'b1, 2);
    chk("after_rst_datos", datos, 8'h7E);
    chk("after_rst_dv", dv_cnt - b_dv, 1);
    chk("after_rst_cv", cv_cnt - b_cv, 0);
`ifdef RECIBIR_PARITY_EN
    snap();
    send_frame(8'h7E, 1'b1, 1'b0, 2);
    chk("par_fe", fe_cnt - b_fe, 1);
    chk("par_dv", dv_cnt - b_dv, 0);
    chk("par_datos", datos, 8'h7E);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
